// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for imem_loader.
// The slave modport is the loader's view; master is the host/memory side.
interface imem_loader_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output s_data, s_valid,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them to instruction memory from address 0.
// Define IMEM_LOADER_CHECKSUM_EN to expect and verify a trailing 32-bit sum word.
module imem_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [8:0]   word_count,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int IDX_W = $clog2(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CSUM, S_FIN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_FIN} state_t;
`endif

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [8:0]         r_count;
    logic [1:0]         r_byte_cnt;
    logic [31:0]        r_word;
    logic [8:0]         w_count_sat;
    logic               w_accept;
    logic               w_last_byte;
    logic               w_last_word;
    logic               w_start;

    assign w_count_sat = (word_count > 9'(MAX_WORDS)) ? 9'(MAX_WORDS) : word_count;
    assign w_start     = (r_state == S_IDLE) && start;
    assign w_accept    = bus.s_valid && bus.s_ready;
    assign w_last_byte = w_accept && (r_byte_cnt == 2'd3);
    assign w_last_word = (9'(r_idx) == r_count - 9'd1);

    // All handshake/status outputs decode from the state register only.
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.s_ready = (r_state == S_RECV) || (r_state == S_CSUM);
`else
    assign bus.s_ready = (r_state == S_RECV);
`endif
    assign bus.mem_we    = (r_state == S_WRITE);
    assign bus.mem_addr  = 32'({r_idx, 2'b00});
    assign bus.mem_wdata = r_word;
    assign busy          = (r_state != S_IDLE);
    assign cpu_hold      = busy;
    assign done          = (r_state == S_FIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = (w_count_sat == 9'd0) ? S_FIN : S_RECV;
            S_RECV:  if (w_last_byte) w_state_next = S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_WRITE: w_state_next = w_last_word ? S_CSUM : S_RECV;
            S_CSUM:  if (w_last_byte) w_state_next = S_FIN;
`else
            S_WRITE: w_state_next = w_last_word ? S_FIN : S_RECV;
`endif
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx      <= '0;
            r_count    <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else begin
            if (w_start) begin
                r_idx      <= '0;
                r_count    <= w_count_sat;
                r_byte_cnt <= '0;
            end
            if (w_accept) begin
                r_word     <= {r_word[23:0], bus.s_data};
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if ((r_state == S_WRITE) && !w_last_word) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_sum;
    logic        r_err;

    // The comparison uses the fully assembled checksum word, so err is ready as FIN begins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_sum <= '0;
                r_err <= 1'b0;
            end
            if (r_state == S_WRITE) begin
                r_sum <= r_sum + r_word;
            end
            if ((r_state == S_CSUM) && w_last_byte) begin
                r_err <= ({r_word[23:0], bus.s_data} != r_sum);
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif
endmodule

// File: doc/imem_loader.md
# imem_loader

Loader that fills the writable instruction memory from a byte stream before the CPU runs. It accepts bytes on a valid/ready handshake, packs every four into a big-endian 32-bit instruction, and writes each word to consecutive word addresses from 0. It holds the CPU stalled until the load completes. It sits between the host/UART byte source and the instruction memory write port.

## Interface
- `MAX_WORDS`, 256: instruction memory depth in words; the word index is `Address[9:2]`.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  one-cycle pulse that begins a load. Sampled only in IDLE.
- `word_count`  in  9  number of words to load. Sampled with `start`. Values above `MAX_WORDS` saturate to `MAX_WORDS`.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction memory write strobe.
- `mem_addr`  out  32  byte address, word-aligned (`{22'b0, idx, 2'b00}`).
- `mem_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  stall/reset request to the CPU while loading.
- `busy`  out  1  loader is not IDLE.
- `done`  out  1  one-cycle pulse when the load finishes.
- `err`  out  1  checksum mismatch, sticky until the next `start`.

## Operation
- States: IDLE, RECV, WRITE, CSUM, FIN.
- **IDLE**
  - `start`=1 with saturated count 0: go to FIN and perform no writes.
  - `start`=1 with count >0: clear the word index, byte counter and `err`, then go to RECV.
- **RECV**
  - `s_ready`=1. A byte is accepted when `s_valid && s_ready`.
  - Packing is big-endian: byte 0 goes to [31:24] and byte 3 to [7:0].
  - After the 4th accepted byte, go to WRITE.
  - Cycles with `s_valid`=0 stall with no state change.
- **WRITE**
  - One cycle: `mem_we`=1, `mem_addr`=idx*4, `mem_wdata`=packed word. `s_ready`=0.
  - If idx == count−1: go to CSUM when the checksum macro is defined, otherwise FIN.
  - Otherwise increment idx and return to RECV.
- **CSUM** (macro only)
  - Receives 4 bytes exactly as in RECV, with no write.
  - Compares the received word against the running sum and sets `err` on mismatch.
  - Then goes to FIN.
- **FIN**: `done`=1 for one cycle, then IDLE.
- `start` while `busy` is ignored.
- `cpu_hold` = `busy`.
- Reset at any point, including mid-load, returns to IDLE immediately. The partially written memory keeps its contents; no further writes occur.

## Timing
- Reset values: `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0, `busy`=0, `done`=0, `err`=0.
- All outputs are registered or decoded from the state only; there is no combinational path from `s_valid` to `s_ready`.
- `start` at edge N gives `busy`=1 and `s_ready`=1 from N+1.
- A 4th byte accepted at edge K gives `mem_we`=1 during cycle K+1 only. `s_ready` returns to 1 at K+2.
- Minimum throughput is 5 cycles per word.
- The final WRITE, or the final CSUM byte, at edge L gives `done`=1 during L+1. `busy` and `cpu_hold` fall at L+2.
- Count 0: `start` at N gives `done` during N+1 and `busy` during N+1 only.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - Running 32-bit sum (mod 2^32) of all written words.
  - One trailing big-endian checksum word is expected after the last data word.
  - `err` is set in FIN on mismatch and is valid when `done` is high.
  - A count-0 load skips CSUM and gives `err`=0.
- Undefined:
  - No CSUM state and no accumulator.
  - `err` is tied to 0.
  - The stream ends after the last data word.

## Test plan
- **Continuous 3-word load:** `word_count`=3, bytes 20 04 2f 5b 24 05 cf c7 00 05 34 00 with `s_valid` held high.
  - Writes: (0x0, 0x20042f5b), (0x4, 0x2405cfc7), (0x8, 0x00053400), each `mem_we` a single cycle.
  - `done` pulses once and `cpu_hold` falls 1 cycle later.
- **Gapped stream:** same bytes, `s_valid` toggled 1/0 every cycle. Identical writes and data, no lost or duplicated bytes.
- **Count 0:** `word_count`=0 → `done` the next cycle, zero `mem_we` pulses. Count 300 with 256 words supplied → the last write is at address 0x3FC, then `done`.
- **Start while busy:** a second `start` during RECV with `word_count`=5 is ignored; the original count of 3 completes.
- **Reset mid-load:** `reset_n` low after 6 bytes → all outputs at their reset values asynchronously, no further `mem_we`. A new `start` restarts at address 0.
- **Checksum (`IMEM_LOADER_CHECKSUM_EN`):**
  - 2 words 0x00000001, 0x00000002 with checksum 0x00000003 → `err`=0.
  - Same words with checksum 0x00000004 → `err`=1 at `done`, cleared by the next `start`.
